// File: rtl/alu_datapath_pkg.sv
// Shared encodings for the ALU datapath: operation codes, multi-cycle FSM states, helpers.
package alu_datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_MUL = 4'd6,
    OP_DIV = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Ops that the single-cycle ALU must never write into Z.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_datapath_seq_muldiv.sv
// Multi-cycle unsigned shift-add multiplier and (with ALU_DATAPATH_DIV_EN) restoring divider.
// Result is presented during FINISH together with the one-cycle done pulse.
module seq_muldiv
  import alu_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DATAPATH_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   div_trial;
`endif

  // MUL keeps the multiplicand in opnd and shifts the product down through {hi,lo};
  // DIV keeps the divisor in opnd, remainder in hi and the dividend/quotient in lo.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    result  = {hi_q, lo_q};
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef ALU_DATAPATH_DIV_EN
    is_div_d  = is_div_q;
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
`endif
    case (state_q)
      IDLE: begin
        if (start && (op == OP_MUL)) begin
          state_d = RUN;
          hi_d    = '0;
          lo_d    = b;
          opnd_d  = a;
          cnt_d   = CW'(WIDTH - 1);
`ifdef ALU_DATAPATH_DIV_EN
          is_div_d = 1'b0;
        end else if (start && (op == OP_DIV)) begin
          is_div_d = 1'b1;
          opnd_d   = b;
          if (b == '0) begin
            state_d = FINISH;
            hi_d    = a;
            lo_d    = '1;
          end else begin
            state_d = RUN;
            hi_d    = '0;
            lo_d    = a;
            cnt_d   = CW'(WIDTH - 1);
          end
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DATAPATH_DIV_EN
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            hi_d = div_trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
`endif
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
`ifdef ALU_DATAPATH_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
`ifdef ALU_DATAPATH_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_datapath.sv
// Single-bus datapath: register file, PC/IR/MAR/MDR/Y/Z, bus mux and single-cycle ALU.
// MUL always, DIV only when ALU_DATAPATH_DIV_EN is defined, run in seq_muldiv.
module alu_datapath
  import alu_datapath_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int RSEL_W = $clog2(NREGS)
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic [WIDTH-1:0]   Mdatain,
  input  logic               Read,
  input  logic               MDRin,
  input  logic               MDRout,
  input  logic               PCin,
  input  logic               PCout,
  input  logic               IncPC,
  input  logic               IRin,
  input  logic               MARin,
  input  logic               Yin,
  input  logic               Rin,
  input  logic               Rout,
  input  logic [RSEL_W-1:0]  RinSel,
  input  logic [RSEL_W-1:0]  RoutSel,
  input  logic               Zin,
  input  logic               Zhiout,
  input  logic               Zlowout,
  input  logic [3:0]         Op,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   BusOut,
  output logic [2*WIDTH-1:0] Zout,
  output logic [WIDTH-1:0]   IRout,
  output logic [WIDTH-1:0]   MARout
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_q [NREGS];
  logic [WIDTH-1:0]   r_d [NREGS];
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d, y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WIDTH-1:0]   bus, alu_hi, alu_lo;
  logic [WIDTH:0]     sum;
  logic               zin_ok;
  logic               md_busy, md_done;
  logic [2*WIDTH-1:0] md_result;

  always_comb begin
    bus = '0;
    if      (Zhiout)  bus = zhi_q;
    else if (Zlowout) bus = zlo_q;
    else if (MDRout)  bus = mdr_q;
    else if (PCout)   bus = pc_q;
    else if (Rout)    bus = r_q[RoutSel];
  end

  // Reserved codes, and MUL/DIV when reached through Zin, produce zero here.
  always_comb begin
    sum    = {1'b0, y_q} + {1'b0, bus};
    alu_hi = '0;
    alu_lo = '0;
    case (Op)
      OP_ADD: begin
        alu_lo = sum[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      end
      OP_SUB: begin
        alu_lo = y_q - bus;
        alu_hi = (y_q < bus) ? '1 : '0;
      end
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_SHL:  alu_lo = y_q << bus[SHW-1:0];
      OP_SHR:  alu_lo = y_q >> bus[SHW-1:0];
      default: alu_lo = '0;
    endcase
  end

`ifdef ALU_DATAPATH_DIV_EN
  assign zin_ok = Zin && !md_busy && !is_muldiv(Op);
`else
  assign zin_ok = Zin && !md_busy && (Op != OP_MUL);
`endif

  always_comb begin
    r_d   = r_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    if (Rin)        r_d[RinSel] = bus;
    if (PCin)       pc_d = bus;
    else if (IncPC) pc_d = pc_q + WIDTH'(1);
    if (IRin)       ir_d  = bus;
    if (MARin)      mar_d = bus;
    if (Yin)        y_d   = bus;
    if (MDRin)      mdr_d = Read ? Mdatain : bus;
    // A finishing multi-cycle result wins over any Zin in the same cycle.
    if (md_done)     {zhi_d, zlo_d} = md_result;
    else if (zin_ok) {zhi_d, zlo_d} = {alu_hi, alu_lo};
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_q   <= '{default: '0};
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      r_q   <= r_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (Clock),
    .clear  (Clear),
    .start  (Start),
    .op     (Op),
    .a      (y_q),
    .b      (bus),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign Busy   = md_busy;
  assign Done   = md_done;
  assign BusOut = bus;
  assign Zout   = {zhi_q, zlo_q};
  assign IRout  = ir_q;
  assign MARout = mar_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath (WIDTH=32): table of single-cycle ALU vectors
// plus hand sequences for multi-cycle, bus priority, PC and Clear corner cases.
module tb_alu_datapath;
  import alu_datapath_pkg::*;

  localparam int WIDTH  = 32;
  localparam int NREGS  = 16;
  localparam int RSEL_W = 4;

  logic              Clock = 1'b0;
  logic              Clear, Read, MDRin, MDRout, PCin, PCout, IncPC, IRin, MARin, Yin;
  logic              Rin, Rout, Zin, Zhiout, Zlowout, Start;
  logic [WIDTH-1:0]  Mdatain;
  logic [RSEL_W-1:0] RinSel, RoutSel;
  logic [3:0]        Op;
  logic              Busy, Done;
  logic [WIDTH-1:0]  BusOut, IRout, MARout;
  logic [2*WIDTH-1:0] Zout;

  alu_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .RSEL_W(RSEL_W)) dut (
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
    .IRin(IRin), .MARin(MARin), .Yin(Yin), .Rin(Rin), .Rout(Rout),
    .RinSel(RinSel), .RoutSel(RoutSel), .Zin(Zin), .Zhiout(Zhiout),
    .Zlowout(Zlowout), .Op(Op), .Start(Start), .Busy(Busy), .Done(Done),
    .BusOut(BusOut), .Zout(Zout), .IRout(IRout), .MARout(MARout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] expq[$];
  int          errors = 0;
  int          checks = 0;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idleStrobes;
    Clear = 0; Read = 0; MDRin = 0; MDRout = 0; PCin = 0; PCout = 0; IncPC = 0;
    IRin = 0; MARin = 0; Yin = 0; Rin = 0; Rout = 0; Zin = 0; Zhiout = 0;
    Zlowout = 0; Start = 0; Op = 4'd0; RinSel = '0; RoutSel = '0; Mdatain = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkZ(input string name);
    logic [63:0] e;
    if (expq.size() == 0) begin
      checkOutput({name, " (scoreboard empty)"}, Zout, ~Zout);
    end else begin
      e = expq.pop_front();
      checkOutput(name, Zout, e);
    end
  endtask

  task automatic loadMdr(input logic [31:0] v);
    idleStrobes(); Mdatain = v; Read = 1; MDRin = 1; tick(); idleStrobes();
  endtask

  task automatic loadY(input logic [31:0] v);
    loadMdr(v); MDRout = 1; Yin = 1; tick(); idleStrobes();
  endtask

  task automatic loadReg(input logic [3:0] idx, input logic [31:0] v);
    loadMdr(v); MDRout = 1; Rin = 1; RinSel = idx; tick(); idleStrobes();
  endtask

  task automatic applyStimulus(input vec_t v);
    loadY(v.y);
    loadMdr(v.b);
    MDRout = 1; Op = v.op; Zin = 1;
    expq.push_back({v.exp_hi, v.exp_lo});
    tick(); idleStrobes();
    checkZ(v.name);
  endtask

  // Launch MUL/DIV with Y=a and bus=b, optionally disturbing it while busy.
  task automatic runMulDiv(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_busy,
                           input bit disturb);
    int          cyc;
    int          busy_cnt;
    logic [63:0] z_before;
    loadY(a);
    loadMdr(b);
    MDRout = 1; Op = op; Start = 1;
    expq.push_back(exp);
    tick(); idleStrobes();
    z_before = Zout;
    cyc = 1; busy_cnt = 0;
    while (!Done && cyc < 200) begin
      if (Busy) busy_cnt++;
      if (disturb && cyc == 5) begin
        MDRout = 1; Op = OP_ADD; Zin = 1;
      end else if (disturb && cyc == 6) begin
        MDRout = 1; Op = OP_MUL; Start = 1;
      end else if (disturb && cyc == 7) begin
        MDRout = 1; Rin = 1; RinSel = 4'd3;
      end
      tick(); idleStrobes();
      if (disturb && (cyc == 5 || cyc == 6))
        checkOutput({name, " Z held while busy"}, Zout, z_before);
      cyc++;
    end
    checkOutput({name, " done cycle"}, 64'(cyc), 64'(exp_busy + 1));
    checkOutput({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    checkOutput({name, " busy low at done"}, 64'(Busy), 64'd0);
    tick();
    checkZ({name, " result"});
    checkOutput({name, " done pulse ends"}, 64'(Done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_seen;
    vecs[0] = '{OP_ADD, 32'd5,          32'd7,          32'd0,          32'd12,         "add 5+7"};
    vecs[1] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0,          "add carry"};
    vecs[2] = '{OP_SUB, 32'd10,         32'd3,          32'd0,          32'd7,          "sub no borrow"};
    vecs[3] = '{OP_SUB, 32'd3,          32'd10,         32'hFFFF_FFFF,  32'hFFFF_FFF9,  "sub borrow"};
    vecs[4] = '{OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0,          32'hF000_F000,  "and"};
    vecs[5] = '{OP_OR,  32'hF0F0_F0F0,  32'h0F0F_0000,  32'd0,          32'hFFFF_F0F0,  "or"};
    vecs[6] = '{OP_SHL, 32'd1,          32'd4,          32'd0,          32'd16,         "shl 4"};
    vecs[7] = '{OP_SHL, 32'h8000_0001,  32'h0000_0021,  32'd0,          32'h0000_0002,  "shl amount masked"};
    vecs[8] = '{OP_SHR, 32'h8000_0000,  32'd31,         32'd0,          32'd1,          "shr 31"};
    vecs[9] = '{4'd9,   32'd5,          32'd7,          32'd0,          32'd0,          "reserved op"};

    idleStrobes();
    Clear = 1; Mdatain = 32'h55; Read = 1; MDRin = 1; PCin = 1;
    tick(); tick();
    idleStrobes();
    checkOutput("reset Z", Zout, 64'd0);
    checkOutput("reset IR", 64'(IRout), 64'd0);
    checkOutput("reset MAR", 64'(MARout), 64'd0);
    checkOutput("reset busy/done", {62'd0, Busy, Done}, 64'd0);
    MDRout = 1; #1;
    checkOutput("reset MDR", 64'(BusOut), 64'd0);
    idleStrobes(); PCout = 1; #1;
    checkOutput("reset PC", 64'(BusOut), 64'd0);
    idleStrobes(); Rout = 1; RoutSel = 4'd5; #1;
    checkOutput("reset R5", 64'(BusOut), 64'd0);
    idleStrobes();

    // R2 = R1 + Y through Z.
    loadReg(4'd1, 32'd7);
    loadY(32'd5);
    Rout = 1; RoutSel = 4'd1; Op = OP_ADD; Zin = 1;
    expq.push_back({32'd0, 32'd12});
    tick(); idleStrobes();
    checkZ("R1+Y into Z");
    Zlowout = 1; Rin = 1; RinSel = 4'd2;
    tick(); idleStrobes();
    Rout = 1; RoutSel = 4'd2; #1;
    checkOutput("R2 from Zlo", 64'(BusOut), 64'd12);
    idleStrobes();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    applyStimulus(vecs[3]);
    loadMdr(32'd9);
    MDRout = 1; Op = OP_MUL; Zin = 1;
    expq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF9});
    tick(); idleStrobes();
    checkZ("Zin with MUL holds Z");

    loadMdr(32'h0000_1234);
    MDRout = 1; IRin = 1; MARin = 1;
    tick(); idleStrobes();
    checkOutput("IR load", 64'(IRout), 64'h1234);
    checkOutput("MAR load", 64'(MARout), 64'h1234);

    loadMdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1; tick(); idleStrobes();
    IncPC = 1; tick(); idleStrobes();
    PCout = 1; #1;
    checkOutput("PC wrap", 64'(BusOut), 64'd0);
    idleStrobes();
    loadMdr(32'h40);
    MDRout = 1; PCin = 1; IncPC = 1; tick(); idleStrobes();
    PCout = 1; #1;
    checkOutput("PCin over IncPC", 64'(BusOut), 64'h40);
    IncPC = 1; tick(); idleStrobes();
    PCout = 1; #1;
    checkOutput("PC increment", 64'(BusOut), 64'h41);
    idleStrobes();

    runMulDiv("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 32, 1'b1);
    Rout = 1; RoutSel = 4'd3; #1;
    checkOutput("R3 loaded while busy", 64'(BusOut), 64'd2);
    idleStrobes();
    runMulDiv("mul small", OP_MUL, 32'd12345, 32'd678, {32'd0, 32'd8369910}, 32, 1'b0);

    loadMdr(32'hAAAA_0000);
    Zhiout = 1; MDRout = 1; Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("bus prio Zhi", 64'(BusOut), 64'd0);
    idleStrobes();
    runMulDiv("mul for prio", OP_MUL, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 32, 1'b0);
    loadMdr(32'hAAAA_0000);
    Zhiout = 1; MDRout = 1; Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("bus prio Zhi over MDR/R", 64'(BusOut), 64'd1);
    idleStrobes(); Zlowout = 1; MDRout = 1; PCout = 1; #1;
    checkOutput("bus prio Zlo", 64'(BusOut), 64'hFFFF_FFFE);
    idleStrobes(); MDRout = 1; PCout = 1; Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("bus prio MDR", 64'(BusOut), 64'hAAAA_0000);
    idleStrobes(); PCout = 1; Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("bus prio PC", 64'(BusOut), 64'h41);
    idleStrobes(); Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("bus R1", 64'(BusOut), 64'd7);
    idleStrobes(); #1;
    checkOutput("bus idle", 64'(BusOut), 64'd0);

`ifdef ALU_DATAPATH_DIV_EN
    runMulDiv("div", OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 1'b0);
    runMulDiv("div by zero", OP_DIV, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 0, 1'b0);
`else
    loadY(32'd100);
    loadMdr(32'd7);
    MDRout = 1; Op = OP_DIV; Start = 1;
    tick(); idleStrobes();
    checkOutput("op7 start ignored", 64'(Busy), 64'd0);
    tick();
    checkOutput("op7 no done", 64'(Done), 64'd0);
    MDRout = 1; Op = OP_DIV; Zin = 1;
    expq.push_back(64'd0);
    tick(); idleStrobes();
    checkZ("op7 Zin as reserved");
`endif

    // Clear in RUN cycle 10 of a MUL, together with other strobes.
    loadY(32'd3);
    loadMdr(32'd5);
    MDRout = 1; Op = OP_MUL; Start = 1;
    tick(); idleStrobes();
    for (int c = 1; c < 10; c++) tick();
    checkOutput("busy before clear", 64'(Busy), 64'd1);
    Clear = 1; MDRout = 1; IRin = 1; PCin = 1; Rin = 1; RinSel = 4'd1;
    tick(); idleStrobes();
    checkOutput("clear aborts busy", 64'(Busy), 64'd0);
    checkOutput("clear zeroes Z", Zout, 64'd0);
    checkOutput("clear over IRin", 64'(IRout), 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done) done_seen++;
      tick();
    end
    checkOutput("no done after abort", 64'(done_seen), 64'd0);
    checkOutput("Z still zero after abort", Zout, 64'd0);
    PCout = 1; #1;
    checkOutput("clear over PCin", 64'(BusOut), 64'd0);
    idleStrobes(); Rout = 1; RoutSel = 4'd1; #1;
    checkOutput("clear over Rin", 64'(BusOut), 64'd0);
    idleStrobes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
